// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command handshake bundle for alu_sequencer
interface alu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - 4-state sequencer driving an external ALU over an 8x32 register file
// Optional sticky overflow flag enabled by macro ALU_SEQ_STICKY_EN.
module alu_sequencer (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_sequencer_if.slave        cmd_if,
    input  logic                  ext_we,
    input  logic [2:0]            ext_addr,
    input  logic [31:0]           ext_data,
    input  logic [2:0]            rd_addr,
    output logic [31:0]           rd_data,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [2:0]            alu_func,
    input  logic [31:0]           alu_result,
    input  logic [3:0]            alu_status,
    output logic                  done,
    output logic [3:0]            flags,
    input  logic                  clr_sticky,
    output logic                  ovf_sticky
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WB} state_t;

    state_t      state;
    logic [31:0] rf [8];
    logic [2:0]  rd_q;
    logic [31:0] res_q;
    logic [3:0]  stat_q;
    logic        ext_hit;
    logic        accept;
    logic        addsub;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign ext_hit = (state == IDLE) && ext_we && (ext_addr != 3'd0);
    assign accept  = (state == IDLE) && cmd_if.cmd_valid;
    assign addsub  = (alu_func[2:1] == 2'b00);

    // An external write landing on the acceptance edge is forwarded so the command sees the new value.
    assign rs1_val = (ext_hit && ext_addr == cmd_if.cmd[5:3]) ? ext_data : rf[cmd_if.cmd[5:3]];
    assign rs2_val = (ext_hit && ext_addr == cmd_if.cmd[2:0]) ? ext_data : rf[cmd_if.cmd[2:0]];

    assign rd_data = rf[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cmd_if.cmd_ready <= 1'b1;
            done             <= 1'b0;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_func         <= '0;
            rd_q             <= '0;
            res_q            <= '0;
            stat_q           <= '0;
            flags            <= '0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ext_hit) rf[ext_addr] <= ext_data;
                    if (accept) begin
                        state            <= ISSUE;
                        cmd_if.cmd_ready <= 1'b0;
                        alu_func         <= cmd_if.cmd[11:9];
                        rd_q             <= cmd_if.cmd[8:6];
                        alu_a            <= rs1_val;
                        alu_b            <= rs2_val;
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    res_q  <= alu_result;
                    stat_q <= alu_status;
                    done   <= 1'b1;
                    state  <= WB;
                end
                WB: begin
                    // R0 is hard-wired to zero, so its write is dropped here.
                    if (rd_q != 3'd0) rf[rd_q] <= res_q;
                    if (addsub) flags <= stat_q;
                    state            <= IDLE;
                    cmd_if.cmd_ready <= 1'b1;
                    alu_a            <= '0;
                    alu_b            <= '0;
                    alu_func         <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_STICKY_EN
    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 ovf_sticky <= 1'b0;
        else if (state == WB && addsub && stat_q[3]) ovf_sticky <= 1'b1;
        else if (clr_sticky)                        ovf_sticky <= 1'b0;
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign ovf_sticky        = 1'b0;
`endif

endmodule
